aes_decipher_block: RTL

AES_DECIPHER_BLOCK -- requirements
Module: aes_decipher_block

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_inv_mixw.sv | 18 +
 rtl/aes_decipher_block.sv | 126 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: key-length codes, round counts, FSM encoding
// and the GF(2^8) constant multipliers (polynomial 0x11b) used by InvMixColumns.
package aes_pkg;

  localparam logic AES_KEYLEN_128 = 1'b0;
  localparam logic AES_KEYLEN_256 = 1'b1;

  localparam int ROUND_W = 4;
  localparam logic [ROUND_W-1:0] AES128_ROUNDS = 4'd10;
  localparam logic [ROUND_W-1:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    SBOX  = 3'd3,
    MAIN  = 3'd4,
    DONE  = 3'd5
  } aes_state_e;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] b);
    return gm2(gm2(b));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] b);
    return gm2(gm4(b));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm8(b) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm8(b) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ gm2(b);
  endfunction

endpackage

// File: rtl/aes_inv_mixw.sv
// InvMixColumns on one 32-bit state column; byte 0 is the MSB.
module aes_inv_mixw
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [7:0] w_b0, w_b1, w_b2, w_b3;

  assign {w_b0, w_b1, w_b2, w_b3} = i_word;

  assign o_word[31:24] = gm14(w_b0) ^ gm11(w_b1) ^ gm13(w_b2) ^ gm09(w_b3);
  assign o_word[23:16] = gm09(w_b0) ^ gm14(w_b1) ^ gm11(w_b2) ^ gm13(w_b3);
  assign o_word[15:8]  = gm13(w_b0) ^ gm09(w_b1) ^ gm14(w_b2) ^ gm11(w_b3);
  assign o_word[7:0]   = gm11(w_b0) ^ gm13(w_b1) ^ gm09(w_b2) ^ gm14(w_b3);

endmodule

// File: rtl/aes_decipher_block.sv
// AES inverse cipher: one round per SHIFT/SBOX/MAIN pass through a shared inverse S-box.
// Define AES_DECIPHER_256_EN to honour keylen (14 rounds); otherwise always 10 rounds.
module aes_decipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  aes_state_e         r_state;
  logic [3:0][31:0]   r_w;
  logic [ROUND_W-1:0] r_round;
  logic [1:0]         r_ctr;
  logic               r_ready;

  logic [3:0][31:0]   w_blk;
  logic [3:0][31:0]   w_shift;
  logic [3:0][31:0]   w_addkey;
  logic [3:0][31:0]   w_mix;
  logic [ROUND_W-1:0] w_nr_start;
  logic [ROUND_W-1:0] w_nr_run;

`ifdef AES_DECIPHER_256_EN
  logic r_keylen;

  assign w_nr_start = (keylen == AES_KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
  assign w_nr_run   = (r_keylen == AES_KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_keylen <= AES_KEYLEN_128;
    end else if (r_state == IDLE && next) begin
      r_keylen <= keylen;
    end
  end
`else
  logic w_unused_keylen;

  assign w_unused_keylen = keylen;
  assign w_nr_start      = AES128_ROUNDS;
  assign w_nr_run        = AES128_ROUNDS;
`endif

  // Column gi takes row gj from column gi-gj: row r rotated right by r bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      assign w_shift[gi][31-8*gj -: 8] = r_w[(gi + 4 - gj) % 4][31-8*gj -: 8];
    end

    assign w_blk[gi]    = block[127-32*gi -: 32];
    assign w_addkey[gi] = ((r_state == INIT) ? w_blk[gi] : r_w[gi]) ^ round_key[127-32*gi -: 32];

    aes_inv_mixw u_mixw (
      .i_word (w_addkey[gi]),
      .o_word (w_mix[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_round <= '0;
      r_ctr   <= '0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (next) begin
            r_round <= w_nr_start;
            r_ready <= 1'b0;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_w     <= w_addkey;
          r_round <= w_nr_run - 4'd1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_w     <= w_shift;
          r_state <= SBOX;
        end
        SBOX: begin
          r_w[r_ctr] <= new_sboxw;
          r_ctr      <= r_ctr + 2'd1;
          if (r_ctr == 2'd3) begin
            r_state <= MAIN;
          end
        end
        MAIN: begin
          if (r_round != '0) begin
            r_w     <= w_mix;
            r_round <= r_round - 4'd1;
            r_state <= SHIFT;
          end else begin
            r_w     <= w_addkey;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign round     = r_round;
  assign sboxw     = (r_state == SBOX) ? r_w[r_ctr] : 32'h0;
  assign new_block = {r_w[0], r_w[1], r_w[2], r_w[3]};
  assign ready     = r_ready;

endmodule
